// File: rtl/nanov_sequencer_pkg.sv
// Shared types and constants for the nanoV instruction sequencer.
package nanov_sequencer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned CYC_W = 3;
  localparam int unsigned OPC_W = 5;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(31);

  // Major opcodes as seen in instr[6:2]
  localparam logic [OPC_W-1:0] OP_JAL    = 5'b11011;
  localparam logic [OPC_W-1:0] OP_JALR   = 5'b11001;
  localparam logic [OPC_W-1:0] OP_BRANCH = 5'b11000;
  localparam logic [OPC_W-1:0] OP_IMM    = 5'b00100;
  localparam logic [OPC_W-1:0] OP_REG    = 5'b01100;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } seq_state_t;

  // Sequential PC increment; the carry out of bit 31 is dropped.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/nanov_sequencer_if.sv
// Fetch handshake plus core-facing timebase and target capture signals.
interface nanov_sequencer_if;
  import nanov_sequencer_pkg::*;

  logic [XLEN-1:0]  instr_in;
  logic             instr_valid;
  logic             instr_ready;
  logic [XLEN-1:0]  fetch_addr;
  logic [XLEN-1:0]  instr;
  logic [CYC_W-1:0] cycle;
  logic [CNT_W-1:0] counter;
  logic             pc;
  logic             core_clk_en;
  logic             branch;
  logic [XLEN-1:0]  data_out;

  // Fetch source and core side (drives instructions, branch strobe, target)
  modport master (
    output instr_in, instr_valid, branch, data_out,
    input  instr_ready, fetch_addr, instr, cycle, counter, pc, core_clk_en
  );

  // Sequencer side
  modport slave (
    input  instr_in, instr_valid, branch, data_out,
    output instr_ready, fetch_addr, instr, cycle, counter, pc, core_clk_en
  );

endinterface

// File: rtl/nanov_sequencer_instr_len.sv
// Decodes how many 32-clock cycles an instruction needs and its control class.
module nanov_sequencer_instr_len
  import nanov_sequencer_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output logic            two_cycle_c_o,
  output logic            is_jmp_c_o,
  output logic            is_branch_c_o
);

  logic [OPC_W-1:0] opcode;
  logic [1:0]       funct3_lo;
  logic             is_shift;
  logic             unused_instr_bits;

  assign opcode    = instr_i[6:2];
  assign funct3_lo = instr_i[13:12];

  // Only opcode and the low funct3 bits affect instruction length
  assign unused_instr_bits = ^{instr_i[31:14], instr_i[11:7], instr_i[1:0]};

  // Classify opcode; shifts need a second pass for the shift amount
  always_comb begin
    is_jmp_c_o    = (opcode == OP_JAL) || (opcode == OP_JALR);
    is_branch_c_o = (opcode == OP_BRANCH);
    is_shift      = ((opcode == OP_IMM) || (opcode == OP_REG)) && (funct3_lo == 2'b01);
    two_cycle_c_o = is_jmp_c_o || is_shift;
  end

endmodule

// File: rtl/nanov_sequencer.sv
// Instruction sequencer for the bit-serial nanoV core: fetch, timebase, PC.
module nanov_sequencer
  import nanov_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rstn,
  nanov_sequencer_if.slave  bus
);

  seq_state_t       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic             instr_ready_q, instr_ready_d;
  logic             core_clk_en_q, core_clk_en_d;

  logic             two_cycle;
  logic             is_jmp;
  logic             is_branch;
  logic             at_last_bit;
  logic             capture;
  logic             complete;
  logic             unused_data_lsb;

  nanov_sequencer_instr_len u_instr_len (
    .instr_i       (instr_q),
    .two_cycle_c_o (two_cycle),
    .is_jmp_c_o    (is_jmp),
    .is_branch_c_o (is_branch)
  );

  // Targets are always halfword aligned, so bit 0 of the core value is dropped
  assign unused_data_lsb = bus.data_out[0];

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= RST;
      pc_q          <= RESET_PC;
      instr_q       <= INSTR_NOP;
      tgt_q         <= '0;
      taken_q       <= 1'b0;
      counter_q     <= '0;
      cycle_q       <= '0;
      instr_ready_q <= 1'b0;
      core_clk_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      tgt_q         <= tgt_d;
      taken_q       <= taken_d;
      counter_q     <= counter_d;
      cycle_q       <= cycle_d;
      instr_ready_q <= instr_ready_d;
      core_clk_en_q <= core_clk_en_d;
    end
  end

  // Next-state, timebase, target capture and PC update
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    tgt_d       = tgt_q;
    taken_d     = taken_q;
    counter_d   = counter_q;
    cycle_d     = cycle_q;
    at_last_bit = (counter_q == CNT_MAX);
    capture     = 1'b0;
    complete    = 1'b0;

    case (state_q)
      RST: begin
        state_d = FETCH;
      end

      FETCH: begin
        counter_d = '0;
        cycle_d   = '0;
        if (bus.instr_valid && instr_ready_q) begin
          instr_d = bus.instr_in;
          taken_d = 1'b0;
          state_d = EXEC;
        end
      end

      EXEC: begin
        counter_d = counter_q + CNT_W'(1);
        if (at_last_bit) begin
          // Jump targets arrive at the end of cycle 0, branch targets at the end of cycle 1
          capture  = (is_jmp && (cycle_q == '0)) || (is_branch && (cycle_q != '0));
          // A branch taken decision at the end of cycle 0 extends it to two cycles
          complete = (cycle_q != '0) || !(two_cycle || (is_branch && bus.branch));
        end
        if (capture) begin
          tgt_d = {bus.data_out[XLEN-1:1], 1'b0};
        end
        if (complete) begin
          // A strobe on the completing edge is too late to redirect this instruction
          pc_d      = (taken_q || is_jmp) ? tgt_d : pc_inc(pc_q);
          counter_d = '0;
          cycle_d   = '0;
          state_d   = FETCH;
        end else begin
          if (bus.branch) begin
            taken_d = 1'b1;
          end
          if (at_last_bit) begin
            cycle_d = cycle_q + CYC_W'(1);
          end
        end
      end

      default: begin
        state_d = RST;
      end
    endcase

    instr_ready_d = (state_d == FETCH);
    core_clk_en_d = (state_d == EXEC);
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.core_clk_en = core_clk_en_q;
  assign bus.fetch_addr  = pc_q;
  assign bus.instr       = instr_q;
  assign bus.cycle       = cycle_q;
  assign bus.counter     = counter_q;
  assign bus.pc          = pc_q[counter_q];

endmodule

// File: tb/tb_nanov_sequencer.sv
// Scoreboard bench for nanov_sequencer: fetch, timebase, serial PC, targets, reset.
module tb_nanov_sequencer;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  nanov_sequencer_if bus ();

  nanov_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    int          len;
    logic [31:0] nxt;
  } exp_t;

  exp_t        sb[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] model_pc;

  task automatic test_reset();
    rstn            = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_in    = '0;
    bus.branch      = 1'b0;
    bus.data_out    = '0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({bus.instr_ready, bus.core_clk_en, bus.counter, bus.cycle} !== 10'd0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got rdy=%b en=%b cnt=%0d cyc=%0d want all 0",
               bus.instr_ready, bus.core_clk_en, bus.counter, bus.cycle);
    end
    vec_cnt++;
    if (bus.instr !== 32'h0000_0013) begin
      err_cnt++;
      $display("FAIL reset_instr: got %h want 00000013", bus.instr);
    end
    vec_cnt++;
    if (bus.fetch_addr !== 32'h0000_0100) begin
      err_cnt++;
      $display("FAIL reset_fetch_addr: got %h want 00000100", bus.fetch_addr);
    end
    rstn = 1'b1;
    #1;
    vec_cnt++;
    if (bus.instr_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_rst_clock_ready: got %b want 0", bus.instr_ready);
    end
    @(negedge clk);
    vec_cnt++;
    if ({bus.instr_ready, bus.core_clk_en} !== 2'b10 || bus.fetch_addr !== 32'h0000_0100) begin
      err_cnt++;
      $display("FAIL reset_release: got rdy=%b en=%b addr=%h want rdy=1 en=0 addr=00000100",
               bus.instr_ready, bus.core_clk_en, bus.fetch_addr);
    end
    model_pc = 32'h0000_0100;
  endtask

  task automatic test_instr(input string nm, input logic [31:0] w, input logic br,
                            input logic [31:0] dout);
    logic [4:0]  opc;
    logic        jmp, shf, bra;
    exp_t        e;
    int          cnt;
    int          wt;
    logic [4:0]  idx;
    logic [31:0] cur_pc;
    logic [8:0]  got_tb, exp_tb;

    opc = w[6:2];
    jmp = (opc == 5'b11011) || (opc == 5'b11001);
    shf = ((opc == 5'b00100) || (opc == 5'b01100)) && (w[13:12] == 2'b01);
    bra = (opc == 5'b11000);
    e.len  = (jmp || shf || (bra && br)) ? 64 : 32;
    e.nxt  = (jmp || (bra && br)) ? {dout[31:1], 1'b0} : model_pc + 32'd4;
    cur_pc = model_pc;

    wt = 0;
    while (bus.instr_ready !== 1'b1 && wt < 5) begin
      @(negedge clk);
      wt++;
    end
    vec_cnt++;
    if (bus.instr_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_ready_timeout: got rdy=%b want 1", nm, bus.instr_ready);
      return;
    end
    vec_cnt++;
    if (bus.fetch_addr !== cur_pc) begin
      err_cnt++;
      $display("FAIL %s_fetch_addr: got %h want %h", nm, bus.fetch_addr, cur_pc);
    end

    bus.instr_in    = w;
    bus.instr_valid = 1'b1;
    bus.data_out    = dout;
    sb.push_back(e);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr_in    = 32'hDEAD_BEEF;
    vec_cnt++;
    if (bus.instr !== w) begin
      err_cnt++;
      $display("FAIL %s_instr_latch: got %h want %h", nm, bus.instr, w);
    end

    cnt = 0;
    while (bus.core_clk_en === 1'b1 && cnt < 200) begin
      idx    = 5'(cnt % 32);
      got_tb = {bus.cycle, bus.counter, bus.pc};
      exp_tb = {3'(cnt / 32), idx, cur_pc[idx]};
      vec_cnt++;
      if (got_tb !== exp_tb || bus.fetch_addr !== cur_pc || bus.instr_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s_exec_clk%0d: got cyc=%0d cnt=%0d pc=%b addr=%h rdy=%b want cyc=%0d cnt=%0d pc=%b addr=%h rdy=0",
                 nm, cnt, bus.cycle, bus.counter, bus.pc, bus.fetch_addr, bus.instr_ready,
                 cnt / 32, idx, cur_pc[idx], cur_pc);
      end
      bus.branch = (bra && br && (cnt == 31)) || (jmp && (cnt == 0));
      @(negedge clk);
      cnt++;
    end
    bus.branch = 1'b0;

    e = sb.pop_front();
    vec_cnt++;
    if (cnt !== e.len) begin
      err_cnt++;
      $display("FAIL %s_exec_len: got %0d clocks want %0d", nm, cnt, e.len);
    end
    vec_cnt++;
    if (bus.fetch_addr !== e.nxt) begin
      err_cnt++;
      $display("FAIL %s_next_pc: got %h want %h", nm, bus.fetch_addr, e.nxt);
    end
    vec_cnt++;
    if ({bus.instr_ready, bus.core_clk_en, bus.counter, bus.cycle} !== 10'b10_00000_000) begin
      err_cnt++;
      $display("FAIL %s_back_in_fetch: got rdy=%b en=%b cnt=%0d cyc=%0d want rdy=1 en=0 cnt=0 cyc=0",
               nm, bus.instr_ready, bus.core_clk_en, bus.counter, bus.cycle);
    end
    model_pc = e.nxt;
  endtask

  task automatic test_idle();
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vec_cnt++;
      if ({bus.instr_ready, bus.core_clk_en, bus.counter, bus.cycle} !== 10'b10_00000_000 ||
          bus.fetch_addr !== model_pc) begin
        err_cnt++;
        $display("FAIL idle_hold%0d: got rdy=%b en=%b cnt=%0d cyc=%0d addr=%h want rdy=1 en=0 cnt=0 cyc=0 addr=%h",
                 i, bus.instr_ready, bus.core_clk_en, bus.counter, bus.cycle, bus.fetch_addr, model_pc);
      end
    end
  endtask

  task automatic test_back_to_back();
    test_instr("sll",       32'h0020_90B3, 1'b0, 32'h0000_0000);
    test_instr("addi_b2b",  32'h0050_0093, 1'b0, 32'h0000_0000);
    test_instr("jalr_hi",   32'h0000_80E7, 1'b0, 32'hFFFF_FFFD);
    test_instr("addi_wrap", 32'h0050_0093, 1'b0, 32'h0000_0000);
  endtask

  task automatic test_reset_mid();
    int wt;
    wt = 0;
    while (bus.instr_ready !== 1'b1 && wt < 5) begin
      @(negedge clk);
      wt++;
    end
    bus.instr_in    = 32'h0080_00EF;
    bus.instr_valid = 1'b1;
    bus.data_out    = 32'h0000_0300;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    wt = 0;
    while (!(bus.cycle === 3'd1 && bus.counter === 5'd17) && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    vec_cnt++;
    if (!(bus.cycle === 3'd1 && bus.counter === 5'd17)) begin
      err_cnt++;
      $display("FAIL midrst_reach: got cyc=%0d cnt=%0d want cyc=1 cnt=17", bus.cycle, bus.counter);
    end
    #2;
    rstn = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.instr_ready, bus.core_clk_en, bus.counter, bus.cycle} !== 10'd0) begin
      err_cnt++;
      $display("FAIL midrst_ctrl: got rdy=%b en=%b cnt=%0d cyc=%0d want all 0",
               bus.instr_ready, bus.core_clk_en, bus.counter, bus.cycle);
    end
    vec_cnt++;
    if (bus.instr !== 32'h0000_0013 || bus.fetch_addr !== 32'h0000_0100) begin
      err_cnt++;
      $display("FAIL midrst_regs: got instr=%h addr=%h want instr=00000013 addr=00000100",
               bus.instr, bus.fetch_addr);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    vec_cnt++;
    if (bus.instr_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrst_rst_clock: got rdy=%b want 0", bus.instr_ready);
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.instr_ready !== 1'b1 || bus.fetch_addr !== 32'h0000_0100) begin
      err_cnt++;
      $display("FAIL midrst_release: got rdy=%b addr=%h want rdy=1 addr=00000100",
               bus.instr_ready, bus.fetch_addr);
    end
    model_pc = 32'h0000_0100;
  endtask

  initial begin
    test_reset();
    test_instr("addi",     32'h0050_0093, 1'b0, 32'h0000_0000);
    test_instr("jal",      32'h0080_00EF, 1'b0, 32'h0000_0203);
    test_instr("beq_nt",   32'h0020_8463, 1'b0, 32'h0000_0999);
    test_instr("beq_t",    32'h0020_8463, 1'b1, 32'h0000_0400);
    test_instr("slli",     32'h0020_9093, 1'b0, 32'h0000_0000);
    test_idle();
    test_back_to_back();
    test_reset_mid();
    test_instr("addi_post", 32'h0050_0093, 1'b0, 32'h0000_0000);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/nanov_sequencer.md
# nanoV_sequencer

Sequencer for the bit-serial nanoV core. It fetches one instruction at a time over a valid/ready handshake and holds it stable. It generates the `cycle`/`counter` timebase and owns the program counter, which it presents to the core one bit per clock. It also captures jump/branch targets from the core and gates the core clock between instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `instr_in` in 32: fetched instruction word.
- `instr_valid` in 1: `instr_in` is valid.
- `instr_ready` out 1: sequencer accepts an instruction; registered.
- `fetch_addr` out 32: address to fetch; equals the PC register.
- `instr` out 32: latched instruction driven to the core.
- `cycle` out 3: instruction cycle index (0 or 1).
- `counter` out 5: bit index within the cycle, 0..31.
- `pc` out 1: `pc_reg[counter]`, the serial PC bit of the current instruction.
- `core_clk_en` out 1: core clock enable; high only in EXEC.
- `branch` in 1: core's branch/jump-taken strobe.
- `data_out` in 32: core stored_data; holds the target at target capture.

## Operation
- States: RST → FETCH → EXEC → FETCH …
  - RST: entered on reset; lasts exactly one clock after `rstn` deasserts.
- FETCH:
  - `instr_ready`=1, `counter`=0, `cycle`=0, `core_clk_en`=0.
  - On `instr_valid && instr_ready`: latch `instr_in` → `instr`, clear `taken`, go to EXEC.
- EXEC:
  - `core_clk_en`=1; `counter` increments every clock and wraps 31→0.
  - At a wrap, `cycle` increments unless the instruction is complete.
- Cycle count is decoded from `instr[6:2]`:
  - JAL 11011, JALR 11001: 2 cycles.
  - OP-IMM 00100 / OP 01100 with `funct3[1:0]`=01 (shifts): 2 cycles.
  - BRANCH 11000: 2 cycles if `branch`=1 on the clock with cycle 0, counter 31; otherwise 1 cycle.
  - All other opcodes: 1 cycle.
- `taken` flag:
  - Set when `branch`=1 in EXEC.
  - JAL/JALR always set it (core strobes at cycle 0, counter 0).
  - Ignored in FETCH/RST.
- Target capture happens at the target cycle's final edge (counter 31):
  - Jumps: end of cycle 0.
  - Branches: end of cycle 1.
  - Capture stores `{data_out[31:1],1'b0}` into `tgt_reg`.
- Instruction completion, at the final edge of the last cycle:
  - `pc_reg` ← `taken ? tgt_reg : pc_reg + 4`, modulo 2^32.
  - Return to FETCH; `counter`/`cycle` go to 0.
- `pc_reg` is constant throughout EXEC, so `pc` always refers to the current instruction's address.
- Reset values:
  - `pc_reg`=`RESET_PC`, `instr`=32'h0000_0013 (NOP).
  - `cycle`=0, `counter`=0, `instr_ready`=0, `core_clk_en`=0, `taken`=0, `tgt_reg`=0.
- Reset asserted mid-EXEC: abort immediately and discard the partial instruction; `pc_reg` returns to `RESET_PC`.

## Timing
- `instr_ready` rises on the first clock edge after the RST clock; it is registered, with no combinational path from `instr_valid`.
- Handshake-to-EXEC latency is 1 clock. `instr` is stable from the first EXEC clock until the next acceptance.
- Throughput, including the single FETCH clock when `instr_valid` is already high:
  - 1-cycle instruction: 32 EXEC clocks + 1 FETCH clock.
  - 2-cycle instruction: 64 EXEC clocks + 1 FETCH clock.
- `instr_valid` low in FETCH: stay in FETCH indefinitely with outputs held.
- `fetch_addr` updates on the completion edge and is valid for the whole FETCH state.
- `branch` high on the same edge as completion still sets `taken` only if the capture rule already applied; a late strobe does not change the completing instruction's next PC.
- PC increment: bit 1:0 of the increment input is always 00; carry out of bit 31 is dropped (0xFFFF_FFFC+4 → 0).

## Structure
- Shared package `nanoV_pkg`:
  - Opcode constants: `OP_JAL`, `OP_JALR`, `OP_BRANCH`, `OP_IMM`, `OP_REG`.
  - `INSTR_NOP` = 32'h0000_0013.
  - State enum `seq_state_t` {RST, FETCH, EXEC}.
- One combinational sub-module, `nanoV_instr_len`: takes `instr` and returns `two_cycle` and `is_jmp`/`is_branch`.
- Everything else is a single sequential module.

## Test plan
- Reset release with `RESET_PC`=0x100 → `instr_ready`=0 for one clock, then 1; `fetch_addr`=0x100.
- ADDI (0x00500093) accepted at PC 0x100 → exactly 32 EXEC clocks with `cycle`=0; `pc` serial bits equal 0x100 LSB-first; next `fetch_addr`=0x104.
- JAL, with `data_out`=0x0000_0203 at the end of cycle 0 → 64 EXEC clocks; next `fetch_addr`=0x202 (bit 0 cleared).
- BEQ, `branch`=0 at cycle 0 counter 31 → completes after 32 clocks, next PC = PC+4. BEQ with `branch`=1 and `data_out`=0x400 at end of cycle 1 → 64 clocks, next PC 0x400.
- SLLI (0x00209093) → 64 EXEC clocks, `cycle` 0 then 1. Then `instr_valid` held low for 10 clocks → FETCH holds, `core_clk_en`=0 and `counter`=0 throughout.
- `rstn` pulsed low at cycle 1 counter 17 of a JAL → all outputs at reset values immediately (async); `instr`=NOP; after release `fetch_addr`=`RESET_PC`. Also cover PC wrap: 0xFFFF_FFFC plus a non-branch → 0x0000_0000.
